// File: rtl/ldm_stm_seq.sv
// ldm_stm_seq: LDM/STM block-transfer sequencer between decode and regfile.
// Walks the register list lowest-first, one memory beat per accepted handshake,
// then optionally writes the updated base back to the regfile.
// Optional feature macro: LDM_PC_LOAD_EN (routes R15 loads to pc_load/pc_val).
module ldm_stm_seq #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREG   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    is_load,
    input  logic                    up,
    input  logic                    pre,
    input  logic                    wback,
    input  logic [$clog2(NREG)-1:0] base_reg,
    input  logic [DATA_W-1:0]       base_val,
    input  logic [NREG-1:0]         reg_list,
    output logic [DATA_W-1:0]       mem_addr,
    output logic                    mem_rd,
    output logic                    mem_wr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic [DATA_W-1:0]       mem_rdata,
    input  logic                    mem_ready,
    output logic [$clog2(NREG)-1:0] rf_r_addr,
    input  logic [DATA_W-1:0]       rf_r_data,
    output logic [$clog2(NREG)-1:0] rf_w_addr,
    output logic [DATA_W-1:0]       rf_w_data,
    output logic                    rf_w_en,
`ifdef LDM_PC_LOAD_EN
    output logic                    pc_load,
    output logic [DATA_W-1:0]       pc_val,
`endif
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned AW = $clog2(NREG);
    localparam int unsigned CW = $clog2(NREG + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_WB   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              is_load_q, is_load_d;
    logic              up_q, up_d;
    logic              wb_en_q, wb_en_d;
    logic [AW-1:0]     base_reg_q, base_reg_d;
    logic [DATA_W-1:0] base_val_q, base_val_d;
    logic [NREG-1:0]   mask_q, mask_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [CW-1:0]     n_q, n_d;

    logic [CW-1:0]     n_in;
    logic [DATA_W-1:0] span_in;
    logic [DATA_W-1:0] span_q;
    logic [AW-1:0]     cur_idx;
    logic [NREG-1:0]   cur_bit;
    logic              last_beat;
    logic              pc_beat;

    // Number of registers in a mask.
    function automatic logic [CW-1:0] popcnt(input logic [NREG-1:0] m);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < NREG; i++) begin
            c = c + CW'(m[i]);
        end
        return c;
    endfunction

    // Index of the lowest set bit (0 when the mask is empty).
    function automatic logic [AW-1:0] lowest(input logic [NREG-1:0] m);
        logic [AW-1:0] idx;
        idx = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (m[i]) begin
                idx = AW'(i);
            end
        end
        return idx;
    endfunction

    // Per-beat decode of the remaining register mask.
    always_comb begin
        n_in      = popcnt(reg_list);
        span_in   = DATA_W'({n_in, 2'b00});
        span_q    = DATA_W'({n_q, 2'b00});
        cur_idx   = lowest(mask_q);
        cur_bit   = NREG'(1) << cur_idx;
        last_beat = ((mask_q & (mask_q - NREG'(1))) == '0);
`ifdef LDM_PC_LOAD_EN
        pc_beat   = is_load_q && (cur_idx == AW'(NREG - 1));
`else
        pc_beat   = 1'b0;
`endif
    end

    // State and transfer-context registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            is_load_q  <= 1'b0;
            up_q       <= 1'b0;
            wb_en_q    <= 1'b0;
            base_reg_q <= '0;
            base_val_q <= '0;
            mask_q     <= '0;
            addr_q     <= '0;
            n_q        <= '0;
        end else begin
            state_q    <= state_d;
            is_load_q  <= is_load_d;
            up_q       <= up_d;
            wb_en_q    <= wb_en_d;
            base_reg_q <= base_reg_d;
            base_val_q <= base_val_d;
            mask_q     <= mask_d;
            addr_q     <= addr_d;
            n_q        <= n_d;
        end
    end

    // Next-state, context update and output decode.
    always_comb begin
        state_d    = state_q;
        is_load_d  = is_load_q;
        up_d       = up_q;
        wb_en_d    = wb_en_q;
        base_reg_d = base_reg_q;
        base_val_d = base_val_q;
        mask_d     = mask_q;
        addr_d     = addr_q;
        n_d        = n_q;

        mem_addr   = '0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_wdata  = '0;
        rf_r_addr  = '0;
        rf_w_addr  = '0;
        rf_w_data  = '0;
        rf_w_en    = 1'b0;
`ifdef LDM_PC_LOAD_EN
        pc_load    = 1'b0;
        pc_val     = '0;
`endif
        busy       = (state_q != S_IDLE);
        done       = (state_q == S_DONE);

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    is_load_d  = is_load;
                    up_d       = up;
                    base_reg_d = base_reg;
                    base_val_d = base_val;
                    mask_d     = reg_list;
                    n_d        = n_in;
                    // A loaded base register beats the written-back base.
                    wb_en_d    = wback && !(is_load && reg_list[base_reg]);
                    unique case ({up, pre})
                        2'b10:   addr_d = base_val;
                        2'b11:   addr_d = base_val + DATA_W'(4);
                        2'b00:   addr_d = base_val - span_in + DATA_W'(4);
                        default: addr_d = base_val - span_in;
                    endcase
                    state_d = (reg_list == '0) ? S_DONE : S_XFER;
                end
            end
            S_XFER: begin
                mem_addr = addr_q;
                mem_rd   = is_load_q;
                mem_wr   = !is_load_q;
                if (is_load_q) begin
                    rf_w_addr = cur_idx;
                    rf_w_data = mem_rdata;
                    rf_w_en   = mem_ready && !pc_beat;
`ifdef LDM_PC_LOAD_EN
                    pc_load   = mem_ready && pc_beat;
                    pc_val    = pc_beat ? mem_rdata : '0;
`endif
                end else begin
                    rf_r_addr = cur_idx;
                    mem_wdata = rf_r_data;
                end
                if (mem_ready) begin
                    mask_d = mask_q & ~cur_bit;
                    addr_d = addr_q + DATA_W'(4);
                    if (last_beat) begin
                        state_d = wb_en_q ? S_WB : S_DONE;
                    end
                end
            end
            S_WB: begin
                rf_w_en   = 1'b1;
                rf_w_addr = base_reg_q;
                rf_w_data = up_q ? (base_val_q + span_q) : (base_val_q - span_q);
                state_d   = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Directed bench for ldm_stm_seq: inputs change 1ns after posedge, outputs
// are checked at negedge. Memory returns addr^0x5A5A0000, regfile reads 0xC0DE0000|addr.
module tb_ldm_stm_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        is_load;
    logic        up;
    logic        pre;
    logic        wback;
    logic [3:0]  base_reg;
    logic [31:0] base_val;
    logic [15:0] reg_list;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [3:0]  rf_r_addr;
    logic [31:0] rf_r_data;
    logic [3:0]  rf_w_addr;
    logic [31:0] rf_w_data;
    logic        rf_w_en;
    logic        busy;
    logic        done;

    int tests;
    int fails;

    ldm_stm_seq #(.DATA_W(32), .NREG(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_load   (is_load),
        .up        (up),
        .pre       (pre),
        .wback     (wback),
        .base_reg  (base_reg),
        .base_val  (base_val),
        .reg_list  (reg_list),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .rf_r_addr (rf_r_addr),
        .rf_r_data (rf_r_data),
        .rf_w_addr (rf_w_addr),
        .rf_w_data (rf_w_data),
        .rf_w_en   (rf_w_en),
        .busy      (busy),
        .done      (done)
    );

    assign mem_rdata = mem_addr ^ 32'h5A5A_0000;
    assign rf_r_data = 32'hC0DE_0000 | {28'd0, rf_r_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to the next cycle's input-drive point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic ld, input logic u, input logic p, input logic wb,
                      input logic [3:0] br, input logic [31:0] bv, input logic [15:0] lst);
        start    = 1'b1;
        is_load  = ld;
        up       = u;
        pre      = p;
        wback    = wb;
        base_reg = br;
        base_val = bv;
        reg_list = lst;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        start = 1'b0;
        is_load = 1'b0;
        up = 1'b0;
        pre = 1'b0;
        wback = 1'b0;
        base_reg = '0;
        base_val = '0;
        reg_list = '0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rfwen", 32'(rf_w_en), 32'd0);
        check("rst_memaddr", mem_addr, 32'd0);
        rst_n = 1'b1;

        // LDMIA R3!, {R0,R2}, base 0x100
        step();
        mem_ready = 1'b1;
        go(1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 32'h100, 16'h0005);
        @(negedge clk);
        check("ia_c0_busy", 32'(busy), 32'd0);
        step(); start = 1'b0;
        @(negedge clk);
        check("ia_b1_addr", mem_addr, 32'h100);
        check("ia_b1_rd", {mem_rd, mem_wr}, 32'd2);
        check("ia_b1_wen", 32'(rf_w_en), 32'd1);
        check("ia_b1_wa", 32'(rf_w_addr), 32'd0);
        check("ia_b1_wd", rf_w_data, 32'h5A5A_0100);
        step();
        @(negedge clk);
        check("ia_b2_addr", mem_addr, 32'h104);
        check("ia_b2_wa", 32'(rf_w_addr), 32'd2);
        check("ia_b2_wd", rf_w_data, 32'h5A5A_0104);
        step();
        @(negedge clk);
        check("ia_wb_rd", 32'(mem_rd), 32'd0);
        check("ia_wb_wen", 32'(rf_w_en), 32'd1);
        check("ia_wb_wa", 32'(rf_w_addr), 32'd3);
        check("ia_wb_wd", rf_w_data, 32'h108);
        check("ia_wb_done", 32'(done), 32'd0);
        step();
        @(negedge clk);
        check("ia_c4_done", 32'(done), 32'd1);
        check("ia_c4_wen", 32'(rf_w_en), 32'd0);
        check("ia_c4_busy", 32'(busy), 32'd1);
        step();
        @(negedge clk);
        check("ia_c5_done", 32'(done), 32'd0);
        check("ia_c5_busy", 32'(busy), 32'd0);

        // STMDB R9, {R0,R15}, base 0x200, no writeback; a second start mid-transfer is ignored
        step();
        go(1'b0, 1'b0, 1'b1, 1'b0, 4'd9, 32'h200, 16'h8001);
        step();
        go(1'b1, 1'b1, 1'b0, 1'b1, 4'd1, 32'h900, 16'h00FF);
        @(negedge clk);
        check("db_b1_addr", mem_addr, 32'h1F8);
        check("db_b1_wr", {mem_rd, mem_wr}, 32'd1);
        check("db_b1_ra", 32'(rf_r_addr), 32'd0);
        check("db_b1_wdata", mem_wdata, 32'hC0DE_0000);
        check("db_b1_wen", 32'(rf_w_en), 32'd0);
        step(); start = 1'b0;
        @(negedge clk);
        check("db_b2_addr", mem_addr, 32'h1FC);
        check("db_b2_ra", 32'(rf_r_addr), 32'd15);
        check("db_b2_wdata", mem_wdata, 32'hC0DE_000F);
        step();
        @(negedge clk);
        check("db_done", 32'(done), 32'd1);
        check("db_nowb", 32'(rf_w_en), 32'd0);
        step();
        @(negedge clk);
        check("db_idle", 32'(busy), 32'd0);

        // LDMIB R0, {R4,R5}, base 0x300, three wait cycles per beat
        step();
        mem_ready = 1'b0;
        go(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 32'h300, 16'h0030);
        step(); start = 1'b0;
        for (int b = 0; b < 2; b++) begin
            for (int w = 0; w < 3; w++) begin
                @(negedge clk);
                check("ib_wait_addr", mem_addr, 32'h304 + 32'(4 * b));
                check("ib_wait_rd", 32'(mem_rd), 32'd1);
                check("ib_wait_wen", 32'(rf_w_en), 32'd0);
                step();
            end
            mem_ready = 1'b1;
            @(negedge clk);
            check("ib_rdy_addr", mem_addr, 32'h304 + 32'(4 * b));
            check("ib_rdy_wen", 32'(rf_w_en), 32'd1);
            check("ib_rdy_wa", 32'(rf_w_addr), 32'd4 + 32'(b));
            step();
            mem_ready = 1'b0;
        end
        @(negedge clk);
        check("ib_done", 32'(done), 32'd1);
        step();

        // Empty list: no strobes, done pulses once, back to idle
        begin
            int strobes;
            int dones;
            int busies;
            strobes = 0;
            dones = 0;
            busies = 0;
            mem_ready = 1'b1;
            go(1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 32'h700, 16'h0000);
            step(); start = 1'b0;
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                if (mem_rd || mem_wr || rf_w_en) strobes++;
                if (done) dones++;
                if (busy) busies++;
                step();
            end
            check("empty_strobes", 32'(strobes), 32'd0);
            check("empty_dones", 32'(dones), 32'd1);
            check("empty_busy_seen", 32'(busies > 0), 32'd1);
            check("empty_idle", 32'(busy), 32'd0);
        end

        // LDMIA R1!, {R1}: loaded value wins, no writeback
        go(1'b1, 1'b1, 1'b0, 1'b1, 4'd1, 32'h800, 16'h0002);
        step(); start = 1'b0;
        @(negedge clk);
        check("bl_wa", 32'(rf_w_addr), 32'd1);
        check("bl_wd", rf_w_data, 32'h5A5A_0800);
        step();
        @(negedge clk);
        check("bl_nowb_wen", 32'(rf_w_en), 32'd0);
        check("bl_done", 32'(done), 32'd1);
        step();

        // STMIA {R0-R3}, reset after the first beat
        go(1'b0, 1'b1, 1'b0, 1'b1, 4'd8, 32'h400, 16'h000F);
        step(); start = 1'b0;
        @(negedge clk);
        check("ab_b1_addr", mem_addr, 32'h400);
        step();
        @(negedge clk);
        check("ab_b2_addr", mem_addr, 32'h404);
        #1 rst_n = 1'b0;
        #1;
        check("ab_busy", 32'(busy), 32'd0);
        check("ab_wr", 32'(mem_wr), 32'd0);
        check("ab_addr", mem_addr, 32'd0);
        check("ab_wen", 32'(rf_w_en), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // LDMDA R6!, {R0,R1}, base 0x500 after the abort
        go(1'b1, 1'b0, 1'b0, 1'b1, 4'd6, 32'h500, 16'h0003);
        step(); start = 1'b0;
        @(negedge clk);
        check("da_b1_addr", mem_addr, 32'h4FC);
        check("da_b1_wa", 32'(rf_w_addr), 32'd0);
        step();
        @(negedge clk);
        check("da_b2_addr", mem_addr, 32'h500);
        step();
        @(negedge clk);
        check("da_wb_wa", 32'(rf_w_addr), 32'd6);
        check("da_wb_wd", rf_w_data, 32'h4F8);
        step();
        @(negedge clk);
        check("da_done", 32'(done), 32'd1);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
